// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared definitions for the EX-stage hazard/forwarding controller:
// forward-bus source codes, FSM state encodings and the shadow-entry layout.
package ex_hazard_ctrl_pkg;

   localparam int REG_AW = 5;

   // Source selected onto the shared EX Forward_data bus
   localparam logic FWD_SRC_MEM = 1'b0;   // ALU result sitting in MEM
   localparam logic FWD_SRC_WB  = 1'b1;   // write data sitting in WB

   typedef enum logic [1:0] {
      HZ_RUN        = 2'd0,
      HZ_LOAD_STALL = 2'd1,
      HZ_CONF_STALL = 2'd2
   } hz_state_e;

   // One in-flight instruction as seen by the hazard logic
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              wen;
      logic              is_load;
   } shadow_entry_t;

   // A producer feeds a consumer operand only if it really writes a
   // non-zero register that the operand really reads.
   function automatic logic entry_match(input shadow_entry_t e,
                                        input logic [REG_AW-1:0] rs,
                                        input logic rs_used);
      return e.valid & e.wen & (e.rd != '0) & rs_used & (e.rd == rs);
   endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// ID-side inputs and EX/IF control outputs of the hazard controller.
// master: pipeline side that drives ID fields; slave: the controller.
interface ex_hazard_ctrl_if;

   logic                               id_valid;
   logic [ex_hazard_ctrl_pkg::REG_AW-1:0] id_rs1;
   logic [ex_hazard_ctrl_pkg::REG_AW-1:0] id_rs2;
   logic                               id_rs1_used;
   logic                               id_rs2_used;
   logic [ex_hazard_ctrl_pkg::REG_AW-1:0] id_rd;
   logic                               id_wen;
   logic                               id_is_load;
   logic                               ex_redirect;

   logic                               stall_if;
   logic                               flush_if_id;
   logic                               flush_id_ex;
   logic                               fwd_a_sel;
   logic                               fwd_b_sel;
   logic                               fwd_src;
   logic [1:0]                         hz_state;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_rd, id_wen, id_is_load, ex_redirect,
      input  stall_if, flush_if_id, flush_id_ex,
             fwd_a_sel, fwd_b_sel, fwd_src, hz_state
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_rd, id_wen, id_is_load, ex_redirect,
      output stall_if, flush_if_id, flush_id_ex,
             fwd_a_sel, fwd_b_sel, fwd_src, hz_state
   );

endinterface

// File: rtl/ex_hazard_ctrl_hz_shadow_pipe.sv
// Shadow EX/MEM/WB chain mirroring the destination info of in-flight
// instructions. A bubble is inserted at EX whenever ID does not advance.
module hz_shadow_pipe
   import ex_hazard_ctrl_pkg::*;
(
   input  logic          cpu_clk,
   input  logic          cpu_rst,
   input  shadow_entry_t id_entry,
   input  logic          bubble,
   output shadow_entry_t ex_entry,
   output shadow_entry_t mem_entry,
   output shadow_entry_t wb_entry
);

   // Shift every edge; EX takes the ID instruction or an invalid bubble.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         ex_entry  <= '0;
         mem_entry <= '0;
         wb_entry  <= '0;
      end else begin
         ex_entry  <= bubble ? shadow_entry_t'('0) : id_entry;
         mem_entry <= ex_entry;
         wb_entry  <= mem_entry;
      end
   end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard/forwarding controller. Detects load-use and shared
// forward-bus conflicts, inserts one-cycle bubbles, and registers the EX
// forward selects plus the single Forward_data source.
// Optional build macro: HAZ_PERF_CNT_EN adds saturating event counters.
module ex_hazard_ctrl
   import ex_hazard_ctrl_pkg::*;
(
   input  logic         cpu_clk,
   input  logic         cpu_rst,
   ex_hazard_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0]  perf_load,
   output logic [31:0]  perf_conf,
   output logic [31:0]  perf_redir
`endif
);

   shadow_entry_t id_entry, ex_entry, mem_entry, wb_entry;
   hz_state_e     state_q, state_nxt;

   logic a_d1, a_d2, b_d1, b_d2;
   logic a_fwd, b_fwd, a_src, b_src;
   logic load_hz, conf_hz, redirect;
   logic stall_if, flush_if_id, flush_id_ex;
   logic fwd_a_q, fwd_b_q, fwd_src_q;

   // WB producers are served by the register-file bypass; the entry is kept
   // only so the shadow chain mirrors the real pipeline for trace.
   logic unused_wb;
   assign unused_wb = ^wb_entry;

   assign id_entry = '{valid: hz.id_valid, rd: hz.id_rd,
                       wen: hz.id_wen, is_load: hz.id_is_load};

   hz_shadow_pipe u_shadow (
      .cpu_clk   (cpu_clk),
      .cpu_rst   (cpu_rst),
      .id_entry  (id_entry),
      .bubble    (flush_id_ex),
      .ex_entry  (ex_entry),
      .mem_entry (mem_entry),
      .wb_entry  (wb_entry)
   );

   // Distance-1 (EX) wins over distance-2 (MEM) for the same operand.
   assign a_d1  = hz.id_valid & entry_match(ex_entry,  hz.id_rs1, hz.id_rs1_used);
   assign a_d2  = hz.id_valid & entry_match(mem_entry, hz.id_rs1, hz.id_rs1_used);
   assign b_d1  = hz.id_valid & entry_match(ex_entry,  hz.id_rs2, hz.id_rs2_used);
   assign b_d2  = hz.id_valid & entry_match(mem_entry, hz.id_rs2, hz.id_rs2_used);
   assign a_fwd = a_d1 | a_d2;
   assign b_fwd = b_d1 | b_d2;
   assign a_src = a_d1 ? FWD_SRC_MEM : FWD_SRC_WB;
   assign b_src = b_d1 ? FWD_SRC_MEM : FWD_SRC_WB;

   // A load result is not on the bus until WB, so a distance-1 load must wait.
   assign load_hz  = (a_d1 | b_d1) & ex_entry.is_load;
   // Both operands forward but from different stages: the one bus cannot serve both.
   assign conf_hz  = a_fwd & b_fwd & (a_src != b_src);
   assign redirect = hz.ex_redirect & ~cpu_rst;

   // Hold the FSM state; reset drops any pending stall immediately.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) state_q <= HZ_RUN;
      else         state_q <= state_nxt;
   end

   // Next state and pipeline controls; redirect overrides, stalls never chain.
   always_comb begin
      state_nxt   = HZ_RUN;
      stall_if    = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      if (redirect) begin
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (state_q == HZ_RUN) begin
         if (load_hz) begin
            stall_if    = 1'b1;
            flush_id_ex = 1'b1;
            state_nxt   = HZ_LOAD_STALL;
         end else if (conf_hz) begin
            stall_if    = 1'b1;
            flush_id_ex = 1'b1;
            state_nxt   = HZ_CONF_STALL;
         end
      end
   end

   // Forward controls for the instruction entering EX; bubbles carry none.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         fwd_a_q   <= 1'b0;
         fwd_b_q   <= 1'b0;
         fwd_src_q <= FWD_SRC_MEM;
      end else if (flush_id_ex) begin
         fwd_a_q   <= 1'b0;
         fwd_b_q   <= 1'b0;
         fwd_src_q <= FWD_SRC_MEM;
      end else begin
         fwd_a_q   <= a_fwd;
         fwd_b_q   <= b_fwd;
         fwd_src_q <= a_fwd ? a_src : (b_fwd ? b_src : FWD_SRC_MEM);
      end
   end

`ifdef HAZ_PERF_CNT_EN
   // Count stall and redirect event cycles, sticking at all-ones.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         perf_load  <= '0;
         perf_conf  <= '0;
         perf_redir <= '0;
      end else begin
         if ((state_nxt == HZ_LOAD_STALL) && (perf_load != '1))  perf_load  <= perf_load + 32'd1;
         if ((state_nxt == HZ_CONF_STALL) && (perf_conf != '1))  perf_conf  <= perf_conf + 32'd1;
         if (redirect && (perf_redir != '1))                     perf_redir <= perf_redir + 32'd1;
      end
   end
`endif

   assign hz.stall_if    = stall_if;
   assign hz.flush_if_id = flush_if_id;
   assign hz.flush_id_ex = flush_id_ex;
   assign hz.fwd_a_sel   = fwd_a_q;
   assign hz.fwd_b_sel   = fwd_b_q;
   assign hz.fwd_src     = fwd_src_q;
   assign hz.hz_state    = state_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an instruction-level model.
module tb_ex_hazard_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   logic cmp_en = 1'b0;

   always #5 clk = ~clk;

   ex_hazard_ctrl_if hif ();

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] perf_load, perf_conf, perf_redir;
   logic [31:0] m_pl, m_pc, m_pr;
`endif

   ex_hazard_ctrl dut (
      .cpu_clk (clk),
      .cpu_rst (rst),
      .hz      (hif)
`ifdef HAZ_PERF_CNT_EN
      ,
      .perf_load  (perf_load),
      .perf_conf  (perf_conf),
      .perf_redir (perf_redir)
`endif
   );

   // ---------------- reference model ----------------
   // Instructions issued into EX (distance 1) and now in MEM (distance 2).
   typedef struct packed { logic v; logic [4:0] rd; logic wen; logic ld; } prod_t;
   prod_t m_d1, m_d2;
   int    m_prev;            // stall kind taken last cycle: 0 none, 1 load, 2 conflict
   logic  m_fa, m_fb, m_fs;  // forward info of the instruction now in EX

   // What an operand needs: 0 register file, 1 MEM result, 2 WB data, 3 wait for load
   function automatic int need(input logic used, input logic [4:0] rs);
      if (!hif.id_valid || !used || rs == 5'd0) return 0;
      if (m_d1.v && m_d1.wen && m_d1.rd == rs) return m_d1.ld ? 3 : 1;
      if (m_d2.v && m_d2.wen && m_d2.rd == rs) return 2;
      return 0;
   endfunction

   // Fate of the ID instruction this cycle: 0 issues, 1 load stall, 2 conflict stall, 3 redirect
   function automatic int decide();
      int na, nb;
      na = need(hif.id_rs1_used, hif.id_rs1);
      nb = need(hif.id_rs2_used, hif.id_rs2);
      if (hif.ex_redirect) return 3;
      if (m_prev != 0) return 0;
      if (na == 3 || nb == 3) return 1;
      if (na != 0 && nb != 0 && na != nb) return 2;
      return 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_d1 <= '0; m_d2 <= '0; m_prev <= 0;
         m_fa <= 1'b0; m_fb <= 1'b0; m_fs <= 1'b0;
`ifdef HAZ_PERF_CNT_EN
         m_pl <= 0; m_pc <= 0; m_pr <= 0;
`endif
      end else begin
         m_d2 <= m_d1;
         if (decide() == 0) begin
            m_d1   <= '{v: hif.id_valid, rd: hif.id_rd, wen: hif.id_wen, ld: hif.id_is_load};
            m_fa   <= need(hif.id_rs1_used, hif.id_rs1) != 0;
            m_fb   <= need(hif.id_rs2_used, hif.id_rs2) != 0;
            m_fs   <= (need(hif.id_rs1_used, hif.id_rs1) != 0) ?
                      (need(hif.id_rs1_used, hif.id_rs1) == 2) :
                      (need(hif.id_rs2_used, hif.id_rs2) == 2);
            m_prev <= 0;
         end else begin
            m_d1   <= '0;
            m_fa   <= 1'b0; m_fb <= 1'b0; m_fs <= 1'b0;
            m_prev <= (decide() == 3) ? 0 : decide();
         end
`ifdef HAZ_PERF_CNT_EN
         if (decide() == 1) m_pl <= m_pl + 1;
         if (decide() == 2) m_pc <= m_pc + 1;
         if (decide() == 3) m_pr <= m_pr + 1;
`endif
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         int k;
         k = rst ? 0 : decide();
         chk("stall_if",    hif.stall_if,    (k == 1 || k == 2));
         chk("flush_id_ex", hif.flush_id_ex, (k != 0));
         chk("flush_if_id", hif.flush_if_id, (k == 3));
         chk("fwd_a_sel",   hif.fwd_a_sel,   m_fa);
         chk("fwd_b_sel",   hif.fwd_b_sel,   m_fb);
         chk("fwd_src",     hif.fwd_src,     m_fs);
         chk("hz_state",    hif.hz_state,    m_prev);
`ifdef HAZ_PERF_CNT_EN
         chk("perf_load",  perf_load,  m_pl);
         chk("perf_conf",  perf_conf,  m_pc);
         chk("perf_redir", perf_redir, m_pr);
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic wen, input logic ld);
      hif.id_valid = v;  hif.id_rs1 = rs1; hif.id_rs2 = rs2;
      hif.id_rs1_used = u1; hif.id_rs2_used = u2;
      hif.id_rd = rd; hif.id_wen = wen; hif.id_is_load = ld;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic idle_drain();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      hif.ex_redirect = 1'b0;
      tick(); tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      hif.ex_redirect = 1'b0;
      cmp_en = 1'b1;
      tick(); tick();
      at_neg();
      chk("reset stall_if", hif.stall_if, 0);
      chk("reset hz_state", hif.hz_state, 0);
      chk("reset fwd_a",    hif.fwd_a_sel, 0);
      tick(); rst = 1'b0;
      tick();

      // 1: add x5 in EX, sub x5,x6 in ID
      set_id(1, 0, 0, 0, 0, 5, 1, 0); tick();
      set_id(1, 5, 6, 1, 1, 8, 1, 0);
      at_neg(); chk("t1 stall_if", hif.stall_if, 0);
      tick(); set_id(0, 0, 0, 0, 0, 0, 0, 0);
      at_neg();
      chk("t1 fwd_a", hif.fwd_a_sel, 1);
      chk("t1 fwd_b", hif.fwd_b_sel, 0);
      chk("t1 src",   hif.fwd_src,   0);
      idle_drain();

      // 2: lw x7 in EX, add using x7 as rs2
      set_id(1, 0, 0, 0, 0, 7, 1, 1); tick();
      set_id(1, 0, 7, 0, 1, 10, 1, 0);
      at_neg();
      chk("t2 stall_if",    hif.stall_if,    1);
      chk("t2 flush_id_ex", hif.flush_id_ex, 1);
      tick();
      at_neg();
      chk("t2 state load", hif.hz_state, 1);
      chk("t2 no chain",   hif.stall_if, 0);
      tick(); set_id(0, 0, 0, 0, 0, 0, 0, 0);
      at_neg();
      chk("t2 state run", hif.hz_state,  0);
      chk("t2 fwd_b",     hif.fwd_b_sel, 1);
      chk("t2 src",       hif.fwd_src,   1);
      idle_drain();

      // 3: add x3 (MEM), add x4 (EX), consumer x3,x4
      set_id(1, 0, 0, 0, 0, 3, 1, 0); tick();
      set_id(1, 0, 0, 0, 0, 4, 1, 0); tick();
      set_id(1, 3, 4, 1, 1, 9, 1, 0);
      at_neg(); chk("t3 stall_if", hif.stall_if, 1);
      tick();
      at_neg(); chk("t3 state conf", hif.hz_state, 2);
      tick(); set_id(0, 0, 0, 0, 0, 0, 0, 0);
      at_neg();
      chk("t3 fwd_a", hif.fwd_a_sel, 0);
      chk("t3 fwd_b", hif.fwd_b_sel, 1);
      chk("t3 src",   hif.fwd_src,   1);
      idle_drain();

      // 4: x0 producer never forwards
      set_id(1, 0, 0, 0, 0, 0, 1, 0); tick();
      set_id(1, 0, 0, 1, 0, 11, 1, 0);
      at_neg(); chk("t4 stall_if", hif.stall_if, 0);
      tick(); set_id(0, 0, 0, 0, 0, 0, 0, 0);
      at_neg(); chk("t4 fwd_a", hif.fwd_a_sel, 0);
      idle_drain();

      // 5: load hazard with a redirect in the same cycle
      set_id(1, 0, 0, 0, 0, 7, 1, 1); tick();
      set_id(1, 0, 7, 0, 1, 12, 1, 0); hif.ex_redirect = 1'b1;
      at_neg();
      chk("t5 flush_if_id", hif.flush_if_id, 1);
      chk("t5 flush_id_ex", hif.flush_id_ex, 1);
      chk("t5 stall_if",    hif.stall_if,    0);
      tick(); hif.ex_redirect = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0, 0);
      at_neg();
      chk("t5 state", hif.hz_state,  0);
      chk("t5 fwd_b", hif.fwd_b_sel, 0);
      idle_drain();

      // 6: reset pulsed during LOAD_STALL
      set_id(1, 0, 0, 0, 0, 7, 1, 1); tick();
      set_id(1, 0, 7, 0, 1, 13, 1, 0); tick();
      chk("t6 in load stall", hif.hz_state, 1);
      rst = 1'b1; #1;
      chk("t6 rst state",  hif.hz_state,    0);
      chk("t6 rst stall",  hif.stall_if,    0);
      chk("t6 rst flush",  hif.flush_id_ex, 0);
      chk("t6 rst fwd_b",  hif.fwd_b_sel,   0);
      tick(); rst = 1'b0;
      set_id(1, 7, 7, 1, 1, 14, 1, 0);
      at_neg(); chk("t6 stale stall", hif.stall_if, 0);
      tick(); set_id(0, 0, 0, 0, 0, 0, 0, 0);
      at_neg();
      chk("t6 stale fwd_a", hif.fwd_a_sel, 0);
      chk("t6 stale fwd_b", hif.fwd_b_sel, 0);
      idle_drain();

      // Randomized traffic with narrow register range to provoke hazards
      for (int c = 0; c < 3000; c++) begin
         set_id(($urandom_range(0, 9) != 0),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                5'($urandom_range(0, 7)),
                ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0));
         hif.ex_redirect = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 199) == 0) rst = 1'b1;
         tick();
         rst = 1'b0;
      end

      idle_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
